// File: rtl/rv_m_pkg.sv
// rv_m_pkg: shared types for the iterative M-extension unit
// funct3 opcodes, FSM states and operand signedness helpers
package rv_m_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } muldiv_state_e;

  function automatic logic is_signed_a(logic [2:0] f3);
    return (f3 == OP_MUL) || (f3 == OP_MULH) ||
           (f3 == OP_MULHSU) || (f3 == OP_DIV) ||
           (f3 == OP_REM);
  endfunction

  function automatic logic is_signed_b(logic [2:0] f3);
    return (f3 == OP_MUL) || (f3 == OP_MULH) ||
           (f3 == OP_DIV) || (f3 == OP_REM);
  endfunction

endpackage

// File: rtl/rv_muldiv_iter_if.sv
// rv_muldiv_iter_if: EX-stage request/response bundle
// master = pipeline side, slave = muldiv unit
interface rv_muldiv_iter_if #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
);
  logic               start;
  logic [2:0]         funct3;
  logic [XLEN-1:0]    op_a;
  logic [XLEN-1:0]    op_b;
  logic [RADDR_W-1:0] rd_in;
  logic               flush;
  logic               stall;
  logic               busy;
  logic               done;
  logic [XLEN-1:0]    result;
  logic [RADDR_W-1:0] rd_out;

  modport master (
    output start, funct3, op_a, op_b, rd_in, flush,
    input  stall, busy, done, result, rd_out
  );

  modport slave (
    input  start, funct3, op_a, op_b, rd_in, flush,
    output stall, busy, done, result, rd_out
  );
endinterface

// File: rtl/md_negate.sv
// md_negate: conditional two's complement of a W-bit value
// used for operand magnitudes and final sign correction
module md_negate #(
  parameter int W = 32
) (
  input  logic         en,
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);
  assign y = en ? (~a + W'(1)) : a;
endmodule

// File: rtl/rv_muldiv_iter.sv
// rv_muldiv_iter: iterative RV32M multiply/divide unit
// shift-add multiply, restoring divide, one-cycle sign fix-up
module rv_muldiv_iter
  import rv_m_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input logic             CLK,
  input logic             RESET_N,
  rv_muldiv_iter_if.slave bus
);
  localparam int MD_CNT_W = $clog2(XLEN);
  localparam logic [MD_CNT_W-1:0] CNT_LAST =
    MD_CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG =
    {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e state_q, state_d;

  logic [2:0]          f3_q;
  logic [RADDR_W-1:0]  rd_q;
  logic [RADDR_W-1:0]  rd_out_q;
  logic [XLEN-1:0]     opnd_q;
  logic [2*XLEN-1:0]   acc_q;
  logic [MD_CNT_W-1:0] cnt_q;
  logic                neg_res_q;
  logic                neg_rem_q;
  logic [XLEN-1:0]     result_q;

  logic            can_acc, accept;
  logic            a_neg, b_neg;
  logic            div_op, div_zero, ovf, special;
  logic [XLEN-1:0] mag_a, mag_b, spec_res;

  assign can_acc = (state_q == S_IDLE) ||
                   (state_q == S_DONE);
  assign accept  = bus.start & can_acc & ~bus.flush;
  assign a_neg   = is_signed_a(bus.funct3) &
                   bus.op_a[XLEN-1];
  assign b_neg   = is_signed_b(bus.funct3) &
                   bus.op_b[XLEN-1];
  assign div_op  = bus.funct3[2];
  assign div_zero = div_op & (bus.op_b == '0);
  assign ovf     = div_op & ~bus.funct3[0] &
                   (bus.op_a == MIN_NEG) & (&bus.op_b);
  assign special = div_zero | ovf;

  md_negate #(.W(XLEN)) u_mag_a (
    .en(a_neg), .a(bus.op_a), .y(mag_a)
  );
  md_negate #(.W(XLEN)) u_mag_b (
    .en(b_neg), .a(bus.op_b), .y(mag_b)
  );

  // result for divides that bypass the iteration
  always_comb begin
    spec_res = bus.op_a;
    if (div_zero)
      spec_res = bus.funct3[1] ? bus.op_a : '1;
    else if (ovf)
      spec_res = bus.funct3[1] ? '0 : bus.op_a;
  end

  logic [XLEN:0]     hi_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     shifted, diff;
  logic [2*XLEN-1:0] div_next;

  // one multiplier bit / one quotient bit per cycle
  always_comb begin
    hi_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} +
             (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {hi_sum, acc_q[XLEN-1:1]};
    shifted = acc_q[2*XLEN-1:XLEN-1];
    diff = shifted - {1'b0, opnd_q};
    if (!diff[XLEN])
      div_next = {diff[XLEN-1:0],
                  acc_q[XLEN-2:0], 1'b1};
    else
      div_next = {shifted[XLEN-1:0],
                  acc_q[XLEN-2:0], 1'b0};
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, rem, fix_res;
  logic              sel_lo, sel_hi, sel_q, sel_r;

  md_negate #(.W(2*XLEN)) u_neg_p (
    .en(neg_res_q), .a(acc_q), .y(prod)
  );
  md_negate #(.W(XLEN)) u_neg_q (
    .en(neg_res_q), .a(acc_q[XLEN-1:0]), .y(quot)
  );
  md_negate #(.W(XLEN)) u_neg_r (
    .en(neg_rem_q), .a(acc_q[2*XLEN-1:XLEN]), .y(rem)
  );

  assign sel_lo = (f3_q == OP_MUL);
  assign sel_hi = ~f3_q[2] & (f3_q != OP_MUL);
  assign sel_q  = f3_q[2] & ~f3_q[1];
  assign sel_r  = f3_q[2] & f3_q[1];

  // pick the half / quotient / remainder for this op
  always_comb begin
    fix_res = '0;
    unique case (1'b1)
      sel_lo: fix_res = prod[XLEN-1:0];
      sel_hi: fix_res = prod[2*XLEN-1:XLEN];
      sel_q:  fix_res = quot;
      sel_r:  fix_res = rem;
      default: fix_res = '0;
    endcase
  end

  // state register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // next state; flush wins over everything
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start)
            state_d = special ? S_DONE :
                      div_op  ? S_DIV  : S_MUL;
          else
            state_d = S_IDLE;
        end
        S_MUL, S_DIV:
          if (cnt_q == CNT_LAST) state_d = S_FIX;
        S_FIX:   state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // operand capture, iteration and result registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      f3_q      <= '0;
      rd_q      <= '0;
      rd_out_q  <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else if (!bus.flush) begin
      if (accept) begin
        f3_q      <= bus.funct3;
        rd_q      <= bus.rd_in;
        cnt_q     <= '0;
        neg_res_q <= a_neg ^ b_neg;
        neg_rem_q <= a_neg;
        if (special) begin
          result_q <= spec_res;
          rd_out_q <= bus.rd_in;
        end else if (div_op) begin
          opnd_q <= mag_b;
          acc_q  <= {{XLEN{1'b0}}, mag_a};
        end else begin
          opnd_q <= mag_a;
          acc_q  <= {{XLEN{1'b0}}, mag_b};
        end
      end else begin
        unique case (state_q)
          S_MUL: begin
            acc_q <= mul_next;
            cnt_q <= cnt_q + MD_CNT_W'(1);
          end
          S_DIV: begin
            acc_q <= div_next;
            cnt_q <= cnt_q + MD_CNT_W'(1);
          end
          S_FIX: begin
            result_q <= fix_res;
            rd_out_q <= rd_q;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.busy = (state_q == S_MUL) ||
                    (state_q == S_DIV) ||
                    (state_q == S_FIX);
  assign bus.done = (state_q == S_DONE);
  assign bus.stall = ~bus.flush &
    ((bus.start & can_acc & ~special) |
     (bus.busy & (state_q != S_FIX)));
  assign bus.result = result_q;
  assign bus.rd_out = rd_out_q;
endmodule
